// File: rtl/oled_receiver.sv
// ----------------------------------------------------------------------------
// oled_receiver
// Display-side end of the four-wire OLED link. Deserialises bytes from
// SDIN/SCLK, decodes the SetX (0x15), SetY (0x75) and SetPixel (0x5C)
// commands, tracks the column/row window and write pointer, and emits one
// RGB565 pixel write for every high/low data byte pair.
//
// Ports:
//   HCLK, HRESETn     system clock, synchronous active-low reset
//   nCS, DnC, SDIN,   serial link (SCLK is synchronous to HCLK)
//   SCLK
//   byte_valid/_data/_dnc  completed-byte report, one cycle per byte
//   pix_we, pix_x, pix_y, pix_data  pixel write strobe, address and colour
//   unknown_cmd       pulse for a command byte outside the decoded set
//
// Decode FSM:
//   state     | meaning
//   IDLE      | no command in progress, data bytes ignored
//   X_START   | SetX seen, waiting for first column
//   X_END     | waiting for last column
//   Y_START   | SetY seen, waiting for first row
//   Y_END     | waiting for last row
//   PIX_HI    | SetPixel active, waiting for colour high byte
//   PIX_LO    | high byte held, waiting for colour low byte
// ----------------------------------------------------------------------------
module oled_receiver #(
    parameter int COLS = 96,
    parameter int ROWS = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        nCS,
    input  logic        DnC,
    input  logic        SDIN,
    input  logic        SCLK,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dnc,
    output logic        pix_we,
    output logic [6:0]  pix_x,
    output logic [5:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        unknown_cmd
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_X_START = 3'd1,
        S_X_END   = 3'd2,
        S_Y_START = 3'd3,
        S_Y_END   = 3'd4,
        S_PIX_HI  = 3'd5,
        S_PIX_LO  = 3'd6
    } state_t;

    localparam logic [7:0] CMD_SET_X   = 8'h15;
    localparam logic [7:0] CMD_SET_Y   = 8'h75;
    localparam logic [7:0] CMD_SET_PIX = 8'h5C;
    localparam logic [6:0] X_MAX       = 7'(COLS - 1);
    localparam logic [5:0] Y_MAX       = 6'(ROWS - 1);

    state_t      state_q, state_d;
    logic        sclk_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [6:0]  col_start_q, col_start_d, col_end_q, col_end_d;
    logic [5:0]  row_start_q, row_start_d, row_end_q, row_end_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [7:0]  hi_q, hi_d;

    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_dnc_q, byte_dnc_d;
    logic        pix_we_q, pix_we_d;
    logic [6:0]  pix_x_q, pix_x_d;
    logic [5:0]  pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        unknown_q, unknown_d;

    logic        bit_edge;
    logic        byte_done;
    logic [7:0]  rx_byte;

    // A held-high SCLK yields one edge only; nCS high masks the edge so a
    // bit coinciding with nCS rising is dropped.
    assign bit_edge  = !nCS && SCLK && !sclk_q;
    assign byte_done = bit_edge && (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q[6:0], SDIN};

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (nCS) begin
            bit_cnt_d = 3'd0;
        end else if (bit_edge) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a command byte always restarts decoding.
    always_comb begin
        state_d = state_q;
        if (byte_done) begin
            if (!DnC) begin
                case (rx_byte)
                    CMD_SET_X:   state_d = S_X_START;
                    CMD_SET_Y:   state_d = S_Y_START;
                    CMD_SET_PIX: state_d = S_PIX_HI;
                    default:     state_d = S_IDLE;
                endcase
            end else begin
                case (state_q)
                    S_X_START: state_d = S_X_END;
                    S_X_END:   state_d = S_IDLE;
                    S_Y_START: state_d = S_Y_END;
                    S_Y_END:   state_d = S_IDLE;
                    S_PIX_HI:  state_d = S_PIX_LO;
                    S_PIX_LO:  state_d = S_PIX_HI;
                    default:   state_d = S_IDLE;
                endcase
            end
        end
    end

    // Output and datapath logic
    always_comb begin
        byte_valid_d = byte_done;
        byte_data_d  = byte_data_q;
        byte_dnc_d   = byte_dnc_q;
        pix_we_d     = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        unknown_d    = 1'b0;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        row_start_d  = row_start_q;
        row_end_d    = row_end_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_d         = hi_q;

        if (byte_done) begin
            byte_data_d = rx_byte;
            byte_dnc_d  = DnC;
            if (!DnC) begin
                unknown_d = (rx_byte != CMD_SET_X) && (rx_byte != CMD_SET_Y) &&
                            (rx_byte != CMD_SET_PIX);
            end else begin
                case (state_q)
                    S_X_START: col_start_d = rx_byte[6:0];
                    S_X_END: begin
                        col_end_d = rx_byte[6:0];
                        x_d       = col_start_q;
                    end
                    S_Y_START: row_start_d = rx_byte[5:0];
                    S_Y_END: begin
                        row_end_d = rx_byte[5:0];
                        y_d       = row_start_q;
                    end
                    S_PIX_HI: hi_d = rx_byte;
                    S_PIX_LO: begin
                        pix_we_d   = 1'b1;
                        pix_x_d    = x_q;
                        pix_y_d    = y_q;
                        pix_data_d = {hi_q, rx_byte};
                        // Wrapping at the panel edge as well as the window end
                        // keeps an inverted window (start > end) on the panel.
                        if ((x_q == col_end_q) || (x_q == X_MAX)) begin
                            x_d = col_start_q;
                            if ((y_q == row_end_q) || (y_q == Y_MAX)) y_d = row_start_q;
                            else                                      y_d = y_q + 6'd1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sclk_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            col_start_q  <= 7'd0;
            col_end_q    <= X_MAX;
            row_start_q  <= 6'd0;
            row_end_q    <= Y_MAX;
            x_q          <= 7'd0;
            y_q          <= 6'd0;
            hi_q         <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_dnc_q   <= 1'b0;
            pix_we_q     <= 1'b0;
            pix_x_q      <= 7'd0;
            pix_y_q      <= 6'd0;
            pix_data_q   <= 16'h0000;
            unknown_q    <= 1'b0;
        end else begin
            sclk_q       <= SCLK;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            row_start_q  <= row_start_d;
            row_end_q    <= row_end_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_q         <= hi_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_dnc_q   <= byte_dnc_d;
            pix_we_q     <= pix_we_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            unknown_q    <= unknown_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_dnc    = byte_dnc_q;
    assign pix_we      = pix_we_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign unknown_cmd = unknown_q;

endmodule
